// File: rtl/candy_ifq.sv
// candy_ifq: instruction prefetch queue between SRAM and candy_id.
// Single-outstanding fetch FSM feeding a small pc/instruction FIFO.
module candy_ifq #(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     sram_re,
    output logic [ADDR_W-1:0]        sram_raddr,
    input  logic                     sram_rready,
    input  logic [DATA_W-1:0]        sram_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [DATA_W-1:0]        inst,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                re_q, re_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [PW-1:0]       wptr_q, wptr_d;
    logic [PW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pcm_q [DEPTH];
    logic [DATA_W-1:0]   dat_q [DEPTH];
    logic                push, pop, issue;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        re_d    = 1'b0;
        raddr_d = raddr_q;
        push    = 1'b0;
        issue   = 1'b0;
        pop     = (cnt_q != '0) && inst_ready && !redirect_valid;
        unique case (state_q)
            S_FETCH: begin
                if (!redirect_valid && fetch_en && cnt_q < CW'(DEPTH)) begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sram_rready) begin
                    push    = !redirect_valid;
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (sram_rready) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (issue) begin
            re_d    = 1'b1;
            raddr_d = pc_q;
            pc_d    = pc_q + 1'b1;
        end
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        // Redirect wins over every other update in its cycle
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            re_q    <= 1'b0;
            raddr_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            re_q    <= re_d;
            raddr_q <= raddr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pcm_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else if (push) begin
            pcm_q[wptr_q] <= raddr_q;
            dat_q[wptr_q] <= sram_rdata;
        end
    end

    assign sram_re    = re_q;
    assign sram_raddr = raddr_q;
    assign inst_valid = (cnt_q != '0);
    assign inst       = dat_q[rptr_q];
    assign inst_pc    = pcm_q[rptr_q];
    assign fifo_count = cnt_q;

endmodule

// File: tb/tb_candy_ifq.sv
// tb_candy_ifq: directed bench for candy_ifq.
// Behavioural SRAM with programmable latency; wrap instance at 0xFFFF.
module tb_candy_ifq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        sram_re;
    logic [15:0] sram_raddr;
    logic        sram_rready = 1'b0;
    logic [31:0] sram_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [15:0] inst_pc;
    logic [2:0]  fifo_count;

    logic        w_re;
    logic [15:0] w_raddr;
    logic        w_rr = 1'b0;
    logic [31:0] w_rdata;
    logic        w_iv;
    logic [31:0] w_inst;
    logic [15:0] w_pc;
    logic [2:0]  w_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bit          manual = 1'b1;
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [15:0] paddr = '0;

    logic [15:0] re_a [$];
    int          re_c [$];
    logic [15:0] pop_pc [$];
    logic [31:0] pop_in [$];
    logic [15:0] wre_a [$];
    logic [15:0] wpop_pc [$];
    logic [31:0] wpop_in [$];

    candy_ifq u_dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .sram_re        (sram_re),
        .sram_raddr     (sram_raddr),
        .sram_rready    (sram_rready),
        .sram_rdata     (sram_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fifo_count     (fifo_count)
    );

    candy_ifq #(.RESET_PC(32'hFFFF)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .sram_re        (w_re),
        .sram_raddr     (w_raddr),
        .sram_rready    (w_rr),
        .sram_rdata     (w_rdata),
        .inst_valid     (w_iv),
        .inst_ready     (inst_ready),
        .inst           (w_inst),
        .inst_pc        (w_pc),
        .fifo_count     (w_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // 1-cycle SRAM for the wrap instance, data = addr + 0x100
    always @(posedge clk) w_rr <= w_re;
    assign w_rdata = {16'h0, w_raddr} + 32'h100;

    // Main SRAM model: rready lat cycles after the re cycle
    always begin
        @(posedge clk);
        #1;
        if (!manual) begin
            sram_rready = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    sram_rready = 1'b1;
                    sram_rdata  = {16'h0, paddr} + 32'h100;
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (sram_re) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = sram_raddr;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && sram_re) begin
            re_a.push_back(sram_raddr);
            re_c.push_back(cyc);
        end
        if (rst && inst_valid && inst_ready && !redirect_valid) begin
            pop_pc.push_back(inst_pc);
            pop_in.push_back(inst);
        end
        if (rst && w_re) wre_a.push_back(w_raddr);
        if (rst && w_iv && inst_ready && !redirect_valid) begin
            wpop_pc.push_back(w_pc);
            wpop_in.push_back(w_inst);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_en       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic wait_re(input string tag, input int lim);
        int k;
        k = 0;
        while (!sram_re && k < lim) begin
            tick();
            k++;
        end
        if (!sram_re) chk(tag, 0, 1);
    endtask

    initial begin
        int b, pb, k, c0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            fetch_en       = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc    = 16'($urandom);
            inst_ready     = 1'($urandom);
            sram_rready    = 1'($urandom);
            sram_rdata     = $urandom;
            tick();
        end
        chk("rst_re", sram_re, 0);
        chk("rst_raddr", sram_raddr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_cnt", fifo_count, 0);

        // Streaming at 1-cycle SRAM
        sram_rready    = 1'b0;
        redirect_valid = 1'b0;
        manual         = 1'b0;
        lat            = 1;
        fetch_en       = 1'b1;
        inst_ready     = 1'b1;
        rst            = 1'b1;
        k = 0;
        while (pop_pc.size() < 3 && k < 40) begin
            tick();
            k++;
        end
        if (pop_pc.size() < 3) chk("tmo_stream", 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("st_re%0d", i), re_a[i], 16'(i));
            chk($sformatf("st_pc%0d", i), pop_pc[i], 16'(i));
            chk($sformatf("st_in%0d", i), pop_in[i], 32'h100 + 32'(i));
        end
        chk("st_gap", 64'(re_c[1] - re_c[0]), 3);

        // Wrap instance: 0xFFFF then 0x0000
        chk("w_re0", wre_a[0], 16'hFFFF);
        chk("w_re1", wre_a[1], 16'h0000);
        chk("w_pc0", wpop_pc[0], 16'hFFFF);
        chk("w_in0", wpop_in[0], 32'h100FF);
        chk("w_pc1", wpop_pc[1], 16'h0000);
        chk("w_in1", wpop_in[1], 32'h100);

        // Full FIFO stops fetching
        do_reset();
        lat      = 1;
        fetch_en = 1'b1;
        k = 0;
        while (fifo_count != 3'd4 && k < 60) begin
            tick();
            k++;
        end
        if (fifo_count != 3'd4) chk("tmo_full", 0, 1);
        b = re_a.size();
        repeat (10) tick();
        chk("full_nore", 64'(re_a.size()), 64'(b));
        chk("full_cnt", fifo_count, 4);
        chk("full_hd", inst_pc, 0);
        pb = pop_pc.size();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        repeat (10) tick();
        chk("full_one", 64'(re_a.size()), 64'(b + 1));
        chk("full_a4", re_a[b], 16'h4);
        chk("full_pop", pop_pc[pb], 0);
        chk("full_cnt2", fifo_count, 4);
        chk("full_hpc", inst_pc, 1);
        chk("full_hin", inst, 32'h101);

        // Redirect while WAIT, 3-cycle SRAM
        do_reset();
        lat        = 3;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        tick();
        wait_re("tmo_rw", 20);
        c0 = cyc;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rw_cnt", fifo_count, 0);
        b  = re_a.size();
        pb = pop_pc.size();
        k = 0;
        while (pop_pc.size() <= pb && k < 40) begin
            tick();
            k++;
        end
        if (pop_pc.size() <= pb) chk("tmo_rwpop", 0, 1);
        chk("rw_addr", re_a[b], 16'h40);
        chk("rw_gap", 64'(re_c[b] - c0), 5);
        chk("rw_pc", pop_pc[pb], 16'h40);
        chk("rw_in", pop_in[pb], 32'h140);

        // Redirect coincident with rready and inst_ready
        do_reset();
        lat      = 1;
        fetch_en = 1'b1;
        tick();
        wait_re("tmo_co0", 20);
        tick();
        wait_re("tmo_co1", 20);
        chk("co_a1", sram_raddr, 1);
        chk("co_cnt1", fifo_count, 1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h80;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk("co_cnt0", fifo_count, 0);
        chk("co_val", inst_valid, 0);
        chk("co_re0", sram_re, 0);
        tick();
        chk("co_re1", sram_re, 1);
        chk("co_addr", sram_raddr, 16'h80);

        // Ten entries through the FIFO with ready toggling
        do_reset();
        lat      = 1;
        fetch_en = 1'b1;
        pb = pop_pc.size();
        k = 0;
        while (pop_pc.size() < pb + 10 && k < 300) begin
            inst_ready = ~inst_ready;
            tick();
            k++;
        end
        if (pop_pc.size() < pb + 10) chk("tmo_wrap", 0, 1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wr_pc%0d", i), pop_pc[pb + i], 16'(i));
            chk($sformatf("wr_in%0d", i), pop_in[pb + i],
                32'h100 + 32'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
